program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_pkg.sv | 36 +++
 rtl/program_sequencer_wait_timer.sv | 36 +++
 rtl/program_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_program_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared processor definitions: sequencer state encoding, default sizing and
// the per-state output decode used by the sequencer and the control decoder.
package program_sequencer_pkg;

    localparam int PROG_LEN_DEF = 16;
    localparam int PC_W_DEF     = 4;
    localparam int WAIT_MAX_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic busy;
        logic reg_wr_gate;
        logic done;
        logic load_ack;
    } seq_out_t;

    // Outputs are a pure function of the state being entered, so they can be
    // registered alongside the state itself.
    function automatic seq_out_t state_outputs(input seq_state_e st);
        seq_out_t o;
        o.busy        = (st != ST_IDLE);
        o.reg_wr_gate = (st == ST_EXEC);
        o.done        = (st == ST_DONE);
        o.load_ack    = (st == ST_LOAD);
        return o;
    endfunction

endpackage

// File: rtl/program_sequencer_wait_timer.sv
// Counts cycles spent waiting on a peripheral handshake and flags when the
// count has reached the configured limit.
module wait_timer
    import program_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic at_limit
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_MAX);

    logic [CNT_W-1:0] cnt_r;

    // Wait counter: zero outside a wait, counts up from zero while waiting, saturates at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else if (!run) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r != CNT_LIMIT) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_limit = run && (cnt_r == CNT_LIMIT);

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: walks the instruction RAM once per control tick, arbitrates
// the RAM port with the program loader and reports overrun/timeout faults.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int PROG_LEN = PROG_LEN_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            load_req,
    input  logic            load_we,
    input  logic            ce_mem,
    input  logic            wt_ready,
    input  logic            halt_op,
    input  logic            clear_err,
    output logic [PC_W-1:0] pc,
    output logic            ram_we,
    output logic            load_ack,
    output logic            reg_wr_gate,
    output logic            busy,
    output logic            done,
    output logic            overrun,
    output logic            timeout
);

    localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1'b1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

    seq_state_e      state_r;
    seq_out_t        out_r;
    logic [PC_W-1:0] pc_r;
    logic            overrun_r;
    logic            timeout_r;

    logic            wait_run_s;
    logic            at_limit_s;
    logic            pc_last_s;
    logic            set_overrun_s;
    logic            set_timeout_s;

    assign wait_run_s    = (state_r == ST_WAIT);
    assign pc_last_s     = (pc_r == PC_LAST);
    // A tick is only consumed from IDLE with no competing load request.
    assign set_overrun_s = tick && ((state_r != ST_IDLE) || load_req);
    assign set_timeout_s = wait_run_s && !wt_ready && at_limit_s;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (wait_run_s),
        .at_limit (at_limit_s)
    );

    // Sequencer FSM; outputs are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            out_r   <= state_outputs(ST_IDLE);
            pc_r    <= PC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_req) begin
                        state_r <= ST_LOAD;
                        out_r   <= state_outputs(ST_LOAD);
                        pc_r    <= PC_ZERO;
                    end else if (tick) begin
                        state_r <= ST_FETCH;
                        out_r   <= state_outputs(ST_FETCH);
                        pc_r    <= PC_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                        out_r   <= state_outputs(ST_IDLE);
                        pc_r    <= pc_r;
                    end
                end
                ST_LOAD: begin
                    pc_r <= PC_ZERO;
                    if (!load_req) begin
                        state_r <= ST_IDLE;
                        out_r   <= state_outputs(ST_IDLE);
                    end else begin
                        state_r <= ST_LOAD;
                        out_r   <= state_outputs(ST_LOAD);
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_EXEC;
                    out_r   <= state_outputs(ST_EXEC);
                    pc_r    <= pc_r;
                end
                ST_EXEC: begin
                    if (halt_op) begin
                        state_r <= ST_DONE;
                        out_r   <= state_outputs(ST_DONE);
                        pc_r    <= pc_r;
                    end else if (ce_mem && !wt_ready) begin
                        state_r <= ST_WAIT;
                        out_r   <= state_outputs(ST_WAIT);
                        pc_r    <= pc_r;
                    end else if (pc_last_s) begin
                        state_r <= ST_DONE;
                        out_r   <= state_outputs(ST_DONE);
                        pc_r    <= pc_r;
                    end else begin
                        state_r <= ST_FETCH;
                        out_r   <= state_outputs(ST_FETCH);
                        pc_r    <= pc_r + PC_ONE;
                    end
                end
                ST_WAIT: begin
                    // A ready arriving in the limit cycle still counts as success.
                    if (wt_ready && pc_last_s) begin
                        state_r <= ST_DONE;
                        out_r   <= state_outputs(ST_DONE);
                        pc_r    <= pc_r;
                    end else if (wt_ready) begin
                        state_r <= ST_FETCH;
                        out_r   <= state_outputs(ST_FETCH);
                        pc_r    <= pc_r + PC_ONE;
                    end else if (at_limit_s) begin
                        state_r <= ST_DONE;
                        out_r   <= state_outputs(ST_DONE);
                        pc_r    <= pc_r;
                    end else begin
                        state_r <= ST_WAIT;
                        out_r   <= state_outputs(ST_WAIT);
                        pc_r    <= pc_r;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    out_r   <= state_outputs(ST_IDLE);
                    pc_r    <= PC_ZERO;
                end
                default: begin
                    state_r <= ST_IDLE;
                    out_r   <= state_outputs(ST_IDLE);
                    pc_r    <= PC_ZERO;
                end
            endcase
        end
    end

    // Sticky fault flags; a set event in the same cycle as clear_err wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            if (set_overrun_s) begin
                overrun_r <= 1'b1;
            end else if (clear_err) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (set_timeout_s) begin
                timeout_r <= 1'b1;
            end else if (clear_err) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign pc          = pc_r;
    assign busy        = out_r.busy;
    assign reg_wr_gate = out_r.reg_wr_gate;
    assign done        = out_r.done;
    assign load_ack    = out_r.load_ack;
    assign ram_we      = load_we && out_r.load_ack;
    assign overrun     = overrun_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus randomized
// programs compared against a per-slot cycle/trace model.
module tb_program_sequencer;

    localparam int PROG_LEN = 16;
    localparam int PC_W     = 4;
    localparam int WAIT_MAX = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0, load_req = 1'b0, load_we = 1'b0, ce_mem = 1'b0;
    logic wt_ready = 1'b0, halt_op = 1'b0, clear_err = 1'b0;
    logic [PC_W-1:0] pc;
    logic ram_we, load_ack, reg_wr_gate, busy, done, overrun, timeout;

    int tests_run = 0;
    int tests_failed = 0;

    bit halt_flag [PROG_LEN];
    bit mem_flag  [PROG_LEN];
    int delay     [PROG_LEN];
    int exp_pcs[$];
    int got_pcs[$];

    program_sequencer #(
        .PROG_LEN (PROG_LEN),
        .PC_W     (PC_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .load_req    (load_req),
        .load_we     (load_we),
        .ce_mem      (ce_mem),
        .wt_ready    (wt_ready),
        .halt_op     (halt_op),
        .clear_err   (clear_err),
        .pc          (pc),
        .ram_we      (ram_we),
        .load_ack    (load_ack),
        .reg_wr_gate (reg_wr_gate),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_program();
        for (int s = 0; s < PROG_LEN; s++) begin
            halt_flag[s] = 1'b0;
            mem_flag[s]  = 1'b0;
            delay[s]     = 0;
        end
    endtask

    task automatic clear_errors();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("clear_overrun", overrun, 32'd0);
        check_eq("clear_timeout", timeout, 32'd0);
    endtask

    // Reference: each executed slot costs FETCH+EXEC, a handshake slot adds its
    // wait cycles (ready cycle included), or WAIT_MAX+1 cycles then timeout.
    task automatic model_pass(output int cycles, output bit to);
        cycles = 0;
        to = 1'b0;
        exp_pcs.delete();
        for (int s = 0; s < PROG_LEN; s++) begin
            cycles += 2;
            exp_pcs.push_back(s);
            if (halt_flag[s]) break;
            if (mem_flag[s] && delay[s] > 0) begin
                if (delay[s] <= WAIT_MAX) begin
                    cycles += delay[s] + 1;
                end else begin
                    cycles += WAIT_MAX + 1;
                    to = 1'b1;
                    break;
                end
            end
        end
    endtask

    // tick_sel: -1 no extra tick, -2 random extra tick, >=0 extra tick at that cycle.
    task automatic run_pass(input string name, input int tick_sel, input bit hold_load);
        int exp_cycles, n, j, cur_d, tick_at, bad_we, bad_ack, done_n;
        bit exp_to, exp_ovr, in_wait, running;
        model_pass(exp_cycles, exp_to);
        tick_at = (tick_sel == -2) ? int'($urandom_range(0, exp_cycles - 1)) : tick_sel;
        exp_ovr = (tick_at >= 0) && (tick_at < exp_cycles);
        got_pcs.delete();
        clear_errors();
        @(negedge clk);
        tick = 1'b1; halt_op = 1'b0; ce_mem = 1'b0; wt_ready = 1'b0;
        in_wait = 1'b0; j = 0; cur_d = 0;
        @(negedge clk);
        n = 0; done_n = -1; bad_we = 0; bad_ack = 0; running = 1'b1;
        while (running) begin
            if (reg_wr_gate) got_pcs.push_back(int'(pc));
            if (ram_we) bad_we++;
            if (load_ack) bad_ack++;
            if (done) begin
                done_n = n;
                running = 1'b0;
            end else if (n > exp_cycles + 40) begin
                check_eq({name, " pass_budget"}, n, exp_cycles);
                running = 1'b0;
            end else begin
                tick = (n == tick_at);
                load_req = hold_load;
                load_we = hold_load;
                halt_op = halt_flag[pc];
                ce_mem = mem_flag[pc];
                if (reg_wr_gate) begin
                    if (!halt_flag[pc] && mem_flag[pc] && delay[pc] > 0) begin
                        in_wait = 1'b1; j = 0; cur_d = delay[pc]; wt_ready = 1'b0;
                    end else if (mem_flag[pc]) begin
                        wt_ready = 1'b1;
                    end else begin
                        wt_ready = 1'($urandom_range(0, 1));
                    end
                end else if (in_wait) begin
                    wt_ready = (j == cur_d);
                    if (j == cur_d) in_wait = 1'b0;
                    j++;
                end else begin
                    wt_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                n++;
            end
        end
        check_eq({name, " cycles"}, done_n, exp_cycles);
        check_eq({name, " timeout"}, timeout, exp_to);
        check_eq({name, " overrun"}, overrun, exp_ovr);
        check_eq({name, " n_gate"}, got_pcs.size(), exp_pcs.size());
        for (int i = 0; i < exp_pcs.size() && i < got_pcs.size(); i++)
            check_eq($sformatf("%s pc_seq[%0d]", name, i), got_pcs[i], exp_pcs[i]);
        check_eq({name, " ram_we_in_pass"}, bad_we, 32'd0);
        check_eq({name, " ack_in_pass"}, bad_ack, 32'd0);
        tick = 1'b0; halt_op = 1'b0; ce_mem = 1'b0; wt_ready = 1'b0;
        @(negedge clk);
        check_eq({name, " idle_after"}, {done, busy, load_ack, pc}, 32'd0);
        if (hold_load) begin
            @(negedge clk);
            check_eq({name, " load_after"}, {load_ack, busy, ram_we}, 32'd7);
            load_req = 1'b0; load_we = 1'b0;
            @(negedge clk);
            check_eq({name, " load_exit"}, {load_ack, busy}, 32'd0);
        end
    endtask

    initial begin
        // Reset holds everything low even with active inputs.
        rst = 1'b0; tick = 1'b1; load_req = 1'b1; load_we = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {pc, ram_we, load_ack, reg_wr_gate, busy, done, overrun, timeout}, 32'd0);
        tick = 1'b0; load_req = 1'b0; load_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_reset_idle", {busy, pc}, 32'd0);

        clear_program();                                run_pass("plain", -1, 1'b0);
        clear_program(); halt_flag[5] = 1'b1;           run_pass("halt5", -1, 1'b0);
        clear_program(); mem_flag[3] = 1'b1; delay[3] = 10;   run_pass("wait10", -1, 1'b0);
        clear_program(); mem_flag[3] = 1'b1; delay[3] = 1000; run_pass("wait_never", -1, 1'b0);
        clear_program(); mem_flag[3] = 1'b1; delay[3] = 255;  run_pass("ready_at_limit", -1, 1'b0);
        clear_program(); mem_flag[15] = 1'b1; delay[15] = 4;  run_pass("wait_last", -1, 1'b0);
        clear_program();                                run_pass("tick_pc7", 14, 1'b0);
        clear_errors();
        clear_program();                                run_pass("load_in_pass", -1, 1'b1);

        // Load request beats a simultaneous tick; the tick is recorded as overrun.
        @(negedge clk);
        load_req = 1'b1; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_eq("load_ack", load_ack, 32'd1);
        check_eq("load_overrun", overrun, 32'd1);
        check_eq("load_pc", pc, 32'd0);
        for (int i = 0; i < 6; i++) begin
            load_we = 1'($urandom_range(0, 1));
            #1;
            check_eq("ram_we_follow", ram_we, load_we);
            @(negedge clk);
        end
        clear_err = 1'b1; tick = 1'b1;
        @(negedge clk);
        clear_err = 1'b0; tick = 1'b0;
        check_eq("set_beats_clear", overrun, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("clear_in_load", overrun, 32'd0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_eq("tick_in_load_drop", {load_ack, pc, reg_wr_gate}, {26'd0, 1'b1, 4'd0, 1'b0});
        check_eq("tick_in_load_ovr", overrun, 32'd1);
        load_req = 1'b0; load_we = 1'b0;
        @(negedge clk);
        check_eq("load_exit", {load_ack, busy}, 32'd0);

        // Reset asserted while waiting at slot 3.
        clear_errors();
        @(negedge clk);
        tick = 1'b1; load_we = 1'b1; ce_mem = 1'b0; wt_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            tick = (n == 8);
            ce_mem = (n >= 6);
            wt_ready = 1'b0;
        end
        @(negedge clk);
        check_eq("wait_state", {busy, reg_wr_gate, pc}, {26'd0, 1'b1, 1'b0, 4'd3});
        check_eq("wait_overrun", overrun, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_in_wait", {pc, ram_we, load_ack, reg_wr_gate, busy, done, overrun, timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b1; ce_mem = 1'b0; load_we = 1'b0;
        clear_program();
        run_pass("after_rst", -1, 1'b0);

        for (int p = 0; p < 24; p++) begin
            for (int s = 0; s < PROG_LEN; s++) begin
                halt_flag[s] = ($urandom_range(0, 24) == 0);
                mem_flag[s]  = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 9))
                    0:       delay[s] = 0;
                    7:       delay[s] = 255;
                    8:       delay[s] = 256;
                    9:       delay[s] = int'($urandom_range(1, 300));
                    default: delay[s] = int'($urandom_range(1, 12));
                endcase
            end
            run_pass($sformatf("rnd%0d", p), ($urandom_range(0, 1) == 1) ? -2 : -1,
                     1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
